// File: rtl/data_mem_responder_if.sv
// CPU-to-data-memory request/response bundle: one request channel, one response strobe.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for a simple CPU: one transaction in flight,
// fixed response latency, faults on misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam int unsigned LAT_M1_I = (LATENCY == 0) ? 0 : LATENCY - 1;
  localparam logic [3:0]  LAT_M1   = LAT_M1_I[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic            fault_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            accept_s;
  logic            req_fault_s;
  logic            in_resp_s;

  assign req_fault_s = (bus.req_addr[1:0] != 2'b00) ||
                       ({2'b00, bus.req_addr[31:2]} >= DEPTH_W);
  assign accept_s    = bus.req_valid && bus.req_ready;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (LATENCY == 0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        write_q <= bus.req_write;
        fault_q <= req_fault_s;
        idx_q   <= bus.req_addr[AW+1:2];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Store commits on the edge ending RESP; reset aborts it but never clears the array.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && write_q && !fault_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign in_resp_s      = !rst && (state_q == RESP);
  assign bus.req_ready  = !rst && (state_q == IDLE);
  assign bus.resp_valid = in_resp_s;
  assign bus.resp_err   = in_resp_s && fault_q;
  assign bus.resp_rdata = (in_resp_s && !write_q && !fault_q) ? mem_q[idx_q] : 32'd0;
  assign bus.busy       = !rst && (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 and LATENCY=0 responders plus a LATENCY 0..15 sweep.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int          sel;
  logic        v, wr;
  logic [31:0] addr, wd;
  logic        o_rv, o_rdy, o_err, o_busy;
  logic [31:0] o_rd;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  data_mem_responder_if b2 ();
  data_mem_responder_if b0 ();

  assign b2.req_valid = v && (sel == 0);
  assign b2.req_write = wr;
  assign b2.req_addr  = addr;
  assign b2.req_wdata = wd;
  assign b0.req_valid = v && (sel == 1);
  assign b0.req_write = wr;
  assign b0.req_addr  = addr;
  assign b0.req_wdata = wd;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_l0 (.clk(clk), .rst(rst), .bus(b0));

  logic [15:0] sw_rv, sw_rdy, sw_err, sw_busy;
  logic [31:0] sw_rd [16];

  for (genvar g = 0; g < 16; g++) begin : g_sw
    data_mem_responder_if bus ();
    assign bus.req_valid = v && (sel == g + 2);
    assign bus.req_write = wr;
    assign bus.req_addr  = addr;
    assign bus.req_wdata = wd;
    data_mem_responder #(.DEPTH(16), .LATENCY(g)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    assign sw_rv[g]   = bus.resp_valid;
    assign sw_rdy[g]  = bus.req_ready;
    assign sw_err[g]  = bus.resp_err;
    assign sw_busy[g] = bus.busy;
    assign sw_rd[g]   = bus.resp_rdata;
  end

  logic [3:0] si;
  always_comb begin
    si     = 4'(sel - 2);
    o_rv   = sw_rv[si];
    o_rdy  = sw_rdy[si];
    o_err  = sw_err[si];
    o_busy = sw_busy[si];
    o_rd   = sw_rd[si];
    if (sel == 0) begin
      o_rv = b2.resp_valid; o_rdy = b2.req_ready; o_err = b2.resp_err;
      o_busy = b2.busy; o_rd = b2.resp_rdata;
    end else if (sel == 1) begin
      o_rv = b0.resp_valid; o_rdy = b0.req_ready; o_err = b0.resp_err;
      o_busy = b0.busy; o_rd = b0.resp_rdata;
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic int lat_of(input int s);
    if (s == 0) return 2;
    else if (s == 1) return 0;
    else return s - 2;
  endfunction

  // One full transaction on the selected responder, checking timing and data.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd, input string nm,
                     output int acc_e, output int rsp_e);
    int lat, first, pulses, quiet_bad;
    logic busy_s, rdy_after, err_s;
    logic [31:0] rd_s;
    lat = lat_of(s);
    first = -1; pulses = 0; quiet_bad = 0; rsp_e = -1;
    busy_s = 1'b0; rdy_after = 1'b0; err_s = 1'b0; rd_s = 32'd0;
    sel = s;
    @(negedge clk);
    chk({nm, " ready_before"}, {31'd0, o_rdy}, 32'd1);
    v = 1'b1; wr = w; addr = a; wd = d;
    @(posedge clk);
    #1;
    v = 1'b0;
    acc_e = edge_cnt;
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      if (n == 1) busy_s = o_busy;
      if (n == lat + 2) rdy_after = o_rdy;
      if (o_rv) begin
        pulses++;
        if (first < 0) begin
          first = n; err_s = o_err; rd_s = o_rd; rsp_e = edge_cnt;
        end
      end else if (o_rd != 32'd0 || o_err) begin
        quiet_bad++;
      end
    end
    chk({nm, " busy"}, {31'd0, busy_s}, 32'd1);
    chk({nm, " resp_cycle"}, first, lat + 1);
    chk({nm, " pulses"}, pulses, 32'd1);
    chk({nm, " err"}, {31'd0, err_s}, {31'd0, e_err});
    chk({nm, " rdata"}, rd_s, e_rd);
    chk({nm, " quiet"}, quiet_bad, 32'd0);
    chk({nm, " ready_after"}, {31'd0, rdy_after}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, rsp, pulses;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 32'h0000_0011, 32'h1111_1111, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'h0000_0000};

    sel = 0; v = 1'b0; wr = 1'b0; addr = 32'd0; wd = 32'd0; rst = 1'b1;

    // Reset: outputs quiet and a request during reset is dropped.
    @(negedge clk);
    v = 1'b1; addr = 32'h10;
    #1;
    chk("rst ready", {31'd0, o_rdy}, 32'd0);
    chk("rst busy", {31'd0, o_busy}, 32'd0);
    chk("rst resp_valid", {31'd0, o_rv}, 32'd0);
    @(negedge clk);
    rst = 1'b0; v = 1'b0;
    #1;
    chk("post_rst ready", {31'd0, o_rdy}, 32'd1);
    chk("post_rst busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      txn(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e_err, vecs[i].e_rd,
          $sformatf("vec%0d", i), acc, rsp);
      if (i == 0) begin
        chk("first accept_edge", acc, 32'd5);
        chk("first resp_edge", rsp, 32'd7);
      end
    end

    txn(1, 1'b0, 32'h0000_0004, 32'd0, 1'b0, 32'h0000_0000, "l0_load4", acc, rsp);
    txn(1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0, 32'h0000_0000, "l0_store8", acc, rsp);
    txn(1, 1'b0, 32'h0000_0008, 32'd0, 1'b0, 32'h0BAD_F00D, "l0_load8", acc, rsp);

    // req_valid held high: acceptance every 4 cycles, one strobe each.
    sel = 0;
    @(negedge clk);
    v = 1'b1; wr = 1'b0; addr = 32'h10;
    for (int p = 0; p < 12; p++) begin
      chk($sformatf("cont p%0d ready", p), {31'd0, o_rdy}, {31'd0, (p % 4) == 0});
      chk($sformatf("cont p%0d resp", p), {31'd0, o_rv}, {31'd0, (p % 4) == 3});
      if ((p % 4) == 3) chk($sformatf("cont p%0d rdata", p), o_rd, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    v = 1'b0;

    // Reset during WAIT aborts a store.
    @(negedge clk);
    v = 1'b1; wr = 1'b1; addr = 32'h20; wd = 32'h1234_5678;
    @(posedge clk);
    #1;
    v = 1'b0;
    @(negedge clk);
    chk("abort wait busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1; v = 1'b1; wr = 1'b0;
    #1;
    chk("abort rst ready", {31'd0, o_rdy}, 32'd0);
    chk("abort rst busy", {31'd0, o_busy}, 32'd0);
    chk("abort rst resp_valid", {31'd0, o_rv}, 32'd0);
    @(negedge clk);
    rst = 1'b0; v = 1'b0;
    #1;
    chk("abort idle busy", {31'd0, o_busy}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (o_rv) pulses++;
    end
    chk("abort no_resp", pulses, 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'h0000_0000, "abort load20", acc, rsp);

    for (int l = 0; l < 16; l++) begin
      txn(l + 2, 1'b1, 32'(l * 4), 32'h5A00_0000 | 32'(l), 1'b0, 32'd0,
          $sformatf("sweep%0d st", l), acc, rsp);
      txn(l + 2, 1'b0, 32'(l * 4), 32'd0, 1'b0, 32'h5A00_0000 | 32'(l),
          $sformatf("sweep%0d ld", l), acc, rsp);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
